scope_capture: RTL and testbench
================================

Name: scope_capture

Overview:
- Parametrised triggered capture engine for the audio oscilloscope labs; successor of the free-running zero-crossing scope.
- Takes a signed microphone/audio sample stream and waits for a configurable level/edge trigger (auto, normal or single-shot mode).
- Stores a decimated record of screen-row values in an internal buffer and serves them to the display through a registered read port.
- Also reports the signal period, measured between consecutive rising crossings of the trigger level.

Parameters:
- w_sample, 24, sample width (signed)
- screen_height, 480, display height; sets the y range
- w_y, $clog2(screen_height), read data width
- depth, 320, buffer entries (points per frame)
- w_addr, $clog2(depth+1), address and count width
- sample_shift, 18-w_y, arithmetic right shift from sample to pixel offset
- w_decim, 8, decimation control width
- auto_timeout, 65535, valid samples without a trigger before auto mode forces capture
- w_period, 20, period counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- sample_valid  in  1  sample strobe
- sample  in  w_sample  signed sample
- trig_level  in  w_sample  signed trigger threshold
- trig_falling  in  1  0 = rising edge, 1 = falling edge
- mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = auto
- arm  in  1  single-shot arm pulse
- frame_ack  in  1  display frame end pulse (e.g. vsync)
- decim  in  w_decim  store every (decim+1)-th valid sample
- rd_addr  in  w_addr  display read index
- rd_data  out  w_y  screen row for rd_addr
- wr_count  out  w_addr  valid entries in the buffer
- state  out  2  0 = IDLE, 1 = WAIT_TRIG, 2 = CAPTURE, 3 = HOLD
- period  out  w_period  samples between rising crossings
- period_valid  out  1  period holds a measurement

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n.
- Reset values: state = IDLE, wr_count = 0, period = 0, period_valid = 0, rd_data = 0, all internal counters = 0, prev sample = 0. Buffer RAM is not reset.
- Everything below advances only on cycles with sample_valid = 1, except the FSM exits IDLE and HOLD and the rd_data path.

Trigger:
- Rising trigger: prev < trig_level and sample >= trig_level.
- Falling trigger: prev >= trig_level and sample < trig_level.
- prev is the last valid sample, signed compare.

FSM:
- IDLE -> WAIT_TRIG next cycle if mode != 2, or if arm = 1.
- WAIT_TRIG:
  - On a trigger sample: -> CAPTURE; wr_count = 0; that sample is written to address 0; decimation counter cleared.
  - Auto modes (0/3): the timeout counter counts valid samples; when it reaches auto_timeout, the current sample is treated as the trigger. The counter clears on entering WAIT_TRIG.
  - Normal (1) and single (2): wait indefinitely.
- CAPTURE:
  - The decimation counter counts valid samples.
  - When the counter equals decim: write at address wr_count, increment wr_count, clear the counter.
  - When wr_count reaches depth: -> HOLD.
  - decim = 0 stores every sample.
- HOLD:
  - mode != 2: -> IDLE on frame_ack.
  - mode = 2: -> IDLE on arm.
  - Other pulses are ignored.
- arm or frame_ack outside their consuming state: ignored.
- mode and decim changes mid-capture take effect at the next WAIT_TRIG and CAPTURE entry respectively; they are latched at those entries.

Stored value:
- Sample is clamped to [-(screen_height/2-1)<<sample_shift, (screen_height/2-1)<<sample_shift].
- Then arithmetic-shifted right by sample_shift.
- Stored as screen_height/2 - shifted, giving rows 1..screen_height-1. Positive sample = higher on screen.

Read port:
- rd_data is registered: buffer[rd_addr] appears 1 cycle after rd_addr.
- rd_addr >= depth returns 0.
- Simultaneous write and read of the same address returns the old data.
- The display must draw only indices < wr_count.

Period:
- A free-running counter of valid samples, independent of the FSM.
- On each rising crossing of trig_level: period <= counter + 1, period_valid <= 1, counter cleared.
- The counter saturates at all-ones and never wraps; period then reads all-ones.

Reset mid-capture: returns to IDLE with wr_count = 0 immediately (asynchronously).

Test Plan:
- Normal mode, trig_level = 0, rising, decim = 0, 1 kHz square ±2^20 at one sample per valid: capture starts on the first -to+ step. buffer[0] = 240 - (min(2^20, 239<<9) >>> 9) = 1. wr_count reaches 320, state = HOLD.
- Auto mode, constant sample = 0 (no crossing): forced capture after exactly 65535 valid samples. All entries = 240.
- decim = 3, ramp sample = n<<9: stored entries step by 4 rows per address. CAPTURE lasts 4*319+1 valid samples.
- Single mode: no capture until arm. frame_ack in HOLD leaves state = HOLD; a second arm re-enters WAIT_TRIG via IDLE.
- Period: rising crossings every 100 valid samples -> period = 100, period_valid = 1. No crossing for 2^20 samples -> the counter saturates and the next crossing reports 0xFFFFF.
- Read latency/reset: rd_addr = 5 returns buffer[5] exactly 1 cycle later. rst_n low mid-CAPTURE -> state = 0, wr_count = 0, period_valid = 0 without a clock edge.

Source files
------------

// File: rtl/scope_capture.sv
// Triggered capture engine for the audio scope labs: level/edge trigger,
// decimated screen-row record with a registered read port, period meter.
module scope_capture #(
  parameter int w_sample      = 24,
  parameter int screen_height = 480,
  parameter int w_y           = $clog2(screen_height),
  parameter int depth         = 320,
  parameter int w_addr        = $clog2(depth + 1),
  parameter int sample_shift  = 18 - w_y,
  parameter int w_decim       = 8,
  parameter int auto_timeout  = 65535,
  parameter int w_period      = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_valid,
  input  logic signed [w_sample-1:0] sample,
  input  logic signed [w_sample-1:0] trig_level,
  input  logic                       trig_falling,
  input  logic [1:0]                 mode,
  input  logic                       arm,
  input  logic                       frame_ack,
  input  logic [w_decim-1:0]         decim,
  input  logic [w_addr-1:0]          rd_addr,
  output logic [w_y-1:0]             rd_data,
  output logic [w_addr-1:0]          wr_count,
  output logic [1:0]                 state,
  output logic [w_period-1:0]        period,
  output logic                       period_valid
);

  localparam int half = screen_height / 2;
  localparam int w_to = $clog2(auto_timeout + 1);

  localparam logic signed [w_sample-1:0] lim_hi =
    w_sample'((half - 1) << sample_shift);
  localparam logic signed [w_sample-1:0] lim_lo = -lim_hi;
  localparam logic [w_to-1:0]     to_last   = w_to'(auto_timeout - 1);
  localparam logic [w_addr-1:0]   last_addr = w_addr'(depth - 1);
  localparam logic [w_addr-1:0]   n_entries = w_addr'(depth);
  localparam logic [w_period-1:0] p_max     = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t st_q, st_d;

  logic signed [w_sample-1:0] prev_q;
  logic [1:0]                 mode_q;
  logic [w_decim-1:0]         decim_q;
  logic [w_decim-1:0]         dcnt_q;
  logic [w_to-1:0]            tcnt_q;
  logic [w_addr-1:0]          wr_count_q;
  logic [w_period-1:0]        pcnt_q;
  logic [w_period-1:0]        period_q;
  logic                       period_valid_q;
  logic [w_y-1:0]             rd_q;

  logic [w_y-1:0] mem [depth];

  logic                       rise;
  logic                       fall;
  logic                       edge_hit;
  logic                       auto_q;
  logic                       trig_hit;
  logic                       store;
  logic                       we;
  logic                       enter_wait;
  logic [w_addr-1:0]          wa;
  logic signed [w_sample-1:0] clamped;
  logic signed [w_sample-1:0] shifted;
  logic signed [w_sample-1:0] row_full;
  logic [w_y-1:0]             wdata;

  assign rise = (prev_q < trig_level) && (sample >= trig_level);
  assign fall = (prev_q >= trig_level) && (sample < trig_level);
  assign edge_hit = trig_falling ? fall : rise;
  assign auto_q = (mode_q == 2'd0) || (mode_q == 2'd3);

  always_comb begin
    clamped = sample;
    unique case (1'b1)
      sample > lim_hi: clamped = lim_hi;
      sample < lim_lo: clamped = lim_lo;
      default: ;
    endcase
  end

  // Screen rows grow downwards, so positive samples map above the midline.
  assign shifted  = clamped >>> sample_shift;
  assign row_full = w_sample'(half) - shifted;
  assign wdata    = row_full[w_y-1:0];

  always_comb begin
    st_d     = st_q;
    trig_hit = 1'b0;
    store    = 1'b0;
    we       = 1'b0;
    wa       = wr_count_q;
    unique case (st_q)
      IDLE: begin
        if (mode != 2'd2 || arm) st_d = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (sample_valid &&
            (edge_hit || (auto_q && tcnt_q == to_last))) begin
          trig_hit = 1'b1;
          we       = 1'b1;
          wa       = '0;
          st_d     = (depth == 1) ? HOLD : CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_valid && dcnt_q == decim_q) begin
          store = 1'b1;
          we    = 1'b1;
          if (wr_count_q == last_addr) st_d = HOLD;
        end
      end
      HOLD: begin
        if ((mode_q == 2'd2) ? arm : frame_ack) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign enter_wait = (st_q == IDLE) && (st_d == WAIT_TRIG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q           <= IDLE;
      prev_q         <= '0;
      mode_q         <= '0;
      decim_q        <= '0;
      dcnt_q         <= '0;
      tcnt_q         <= '0;
      wr_count_q     <= '0;
      pcnt_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      rd_q           <= '0;
    end else begin
      st_q <= st_d;
      if (sample_valid) prev_q <= sample;
      if (enter_wait) begin
        mode_q <= mode;
        tcnt_q <= '0;
      end else if (st_q == WAIT_TRIG && sample_valid &&
                   tcnt_q != to_last) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      // The trigger sample is entry 0, so the record starts one entry full.
      if (trig_hit) begin
        wr_count_q <= w_addr'(1);
        dcnt_q     <= '0;
        decim_q    <= decim;
      end else if (st_q == CAPTURE && sample_valid) begin
        if (store) begin
          wr_count_q <= wr_count_q + 1'b1;
          dcnt_q     <= '0;
        end else begin
          dcnt_q <= dcnt_q + 1'b1;
        end
      end
      if (sample_valid && rise) begin
        period_q       <= (pcnt_q == p_max) ? p_max : pcnt_q + 1'b1;
        period_valid_q <= 1'b1;
        pcnt_q         <= '0;
      end else if (sample_valid && pcnt_q != p_max) begin
        pcnt_q <= pcnt_q + 1'b1;
      end
      rd_q <= (rd_addr < n_entries) ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wdata;
  end

  assign rd_data      = rd_q;
  assign wr_count     = wr_count_q;
  assign state        = st_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_scope_capture.sv
// Randomised bench for scope_capture: triggers, decimation, read port,
// period meter and async reset against a behavioural model.
module tb_scope_capture;

  localparam int WS    = 24;
  localparam int SH    = 480;
  localparam int WY    = $clog2(SH);
  localparam int DEPTH = 320;
  localparam int WA    = $clog2(DEPTH + 1);
  localparam int SHIFT = 18 - WY;
  localparam int WD    = 8;
  localparam int TO    = 700;
  localparam int WP    = 12;
  localparam int HALF  = SH / 2;
  localparam int LIM   = (HALF - 1) * (2 ** SHIFT);
  localparam int PMAX  = (2 ** WP) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [WS-1:0] sample = '0;
  logic [WS-1:0] trig_level = '0;
  logic          trig_falling = 1'b0;
  logic [1:0]    mode = 2'd2;
  logic          arm = 1'b0;
  logic          frame_ack = 1'b0;
  logic [WD-1:0] decim = '0;
  logic [WA-1:0] rd_addr = '0;
  logic [WY-1:0] rd_data;
  logic [WA-1:0] wr_count;
  logic [1:0]    state;
  logic [WP-1:0] period;
  logic          period_valid;

  int checks = 0;
  int failures = 0;
  int prev_m = 0;
  int stim[$];
  int exp_row[DEPTH];

  scope_capture #(
    .auto_timeout(TO),
    .w_period(WP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_valid(sample_valid),
    .sample(sample),
    .trig_level(trig_level),
    .trig_falling(trig_falling),
    .mode(mode),
    .arm(arm),
    .frame_ack(frame_ack),
    .decim(decim),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_count(wr_count),
    .state(state),
    .period(period),
    .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  function automatic int row_of(input int s);
    int c;
    c = s;
    if (c > LIM) c = LIM;
    if (c < -LIM) c = -LIM;
    return HALF - (c >>> SHIFT);
  endfunction

  function automatic int rnd(input int r);
    return int'($urandom_range(2 * r, 0)) - r;
  endfunction

  // Always entered and left on a falling clock edge.
  task automatic drive_valid(input int s, input int gapmax);
    sample = WS'(s);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sample = WS'($urandom);
    prev_m = s;
    if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) @(negedge clk);
  endtask

  task automatic capture_run(input string nm, input int lvl,
                             input bit fall, input bit auto_m,
                             input int dec, input int gapmax);
    int t;
    int last;
    int p;
    t = -1;
    p = prev_m;
    for (int i = 0; i < stim.size(); i++) begin
      if ((fall ? (p >= lvl && stim[i] < lvl) : (p < lvl && stim[i] >= lvl))
          || (auto_m && i + 1 == TO)) begin
        t = i;
        break;
      end
      p = stim[i];
    end
    last = t + (DEPTH - 1) * (dec + 1);
    checks++;
    if (t < 0 || last >= stim.size()) begin
      failures++;
      $display("FAIL %s_stim: trigger=%0d last=%0d size=%0d", nm, t, last,
               stim.size());
      return;
    end
    trig_level = WS'(lvl);
    trig_falling = fall;
    decim = WD'(dec);
    for (int i = 0; i <= last; i++) begin
      drive_valid(stim[i], gapmax);
      if (i == t) decim = WD'($urandom);
      if (i == t - 1) begin
        checks++;
        if (state !== 2'd1) begin
          failures++;
          $display("FAIL %s_pretrig: state=%0d expected 1", nm, state);
        end
      end
      if (i == t || i == last - 1) begin
        checks++;
        if (state !== 2'd2) begin
          failures++;
          $display("FAIL %s_capture@%0d: state=%0d expected 2", nm, i, state);
        end
      end
    end
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL %s_hold: state=%0d expected 3", nm, state);
    end
    checks++;
    if (wr_count !== WA'(DEPTH)) begin
      failures++;
      $display("FAIL %s_count: wr_count=%0d expected %0d", nm, wr_count, DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) exp_row[k] = row_of(stim[t + k * (dec + 1)]);
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr = WA'(k);
      @(negedge clk);
      checks++;
      if (int'(rd_data) !== exp_row[k]) begin
        failures++;
        $display("FAIL %s_data[%0d]: got=%0d expected %0d", nm, k, rd_data,
                 exp_row[k]);
      end
    end
  endtask

  task automatic leave_hold(input string nm, input logic [1:0] nxt);
    logic [1:0] e;
    e = (nxt == 2'd2) ? 2'd0 : 2'd1;
    mode = nxt;
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL %s_ack_idle: state=%0d expected 0", nm, state);
    end
    @(negedge clk);
    checks++;
    if (state !== e) begin
      failures++;
      $display("FAIL %s_rearm: state=%0d expected %0d", nm, state, e);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 2'd0 || wr_count !== '0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_fsm: state=%0d wr_count=%0d rd_data=%0d expected 0",
               state, wr_count, rd_data);
    end
    checks++;
    if (period !== '0 || period_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_period: period=%0d valid=%0d expected 0",
               period, period_valid);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL reset_single_idle: state=%0d expected 0", state);
    end
  endtask

  task automatic test_normal_square();
    int v;
    mode = 2'd1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL square_wait: state=%0d expected 1", state);
    end
    stim.delete();
    repeat ($urandom_range(30, 3)) stim.push_back(-(1 << 20));
    while (stim.size() < 760) begin
      v = (1 << 20) + int'($urandom_range(5000, 0));
      repeat (24) stim.push_back(v);
      repeat (24) stim.push_back(-v);
    end
    capture_run("square", 0, 1'b0, 1'b0, 0, 1);
    rd_addr = '0;
    @(negedge clk);
    checks++;
    if (rd_data !== WY'(1)) begin
      failures++;
      $display("FAIL square_row0: got=%0d expected 1", rd_data);
    end
    leave_hold("square", 2'd1);
  endtask

  task automatic test_decim_ramp();
    stim.delete();
    for (int n = -5; n <= 1290; n++) stim.push_back(n * (2 ** SHIFT));
    capture_run("ramp", 0, 1'b0, 1'b0, 3, 0);
    leave_hold("ramp", 2'd0);
  endtask

  task automatic test_auto_timeout();
    stim.delete();
    repeat (TO + DEPTH + 10) stim.push_back(0);
    capture_run("auto", 0, 1'b0, 1'b1, 0, 1);
    leave_hold("auto", 2'd1);
  endtask

  task automatic test_falling_random();
    int lvl;
    mode = 2'd2;
    lvl = rnd(50000);
    stim.delete();
    repeat (1100) stim.push_back(rnd(300000));
    capture_run("fall", lvl, 1'b1, 1'b0, int'($urandom_range(2, 0)), 2);
    leave_hold("fall", 2'd2);
    @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL fall_stay_idle: state=%0d expected 0", state);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 6; i++) drive_valid((i % 2) ? 5000 : -5000, 0);
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL single_no_arm: state=%0d expected 0", state);
    end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL single_arm: state=%0d expected 1", state);
    end
    stim.delete();
    repeat (800) stim.push_back(rnd(200000));
    capture_run("single", 0, 1'b0, 1'b0, 1, 1);
  endtask

  task automatic test_read_port();
    rd_addr = WA'(7);
    @(negedge clk);
    rd_addr = WA'(5);
    #1;
    checks++;
    if (int'(rd_data) !== exp_row[7]) begin
      failures++;
      $display("FAIL rd_latency_old: got=%0d expected %0d", rd_data, exp_row[7]);
    end
    @(negedge clk);
    checks++;
    if (int'(rd_data) !== exp_row[5]) begin
      failures++;
      $display("FAIL rd_latency_new: got=%0d expected %0d", rd_data, exp_row[5]);
    end
    rd_addr = WA'(DEPTH);
    @(negedge clk);
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL rd_oob_depth: got=%0d expected 0", rd_data);
    end
    rd_addr = '1;
    @(negedge clk);
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL rd_oob_max: got=%0d expected 0", rd_data);
    end
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL single_ack_ignored: state=%0d expected 3", state);
    end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL single_rel: state=%0d expected 0", state);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL single_idle_hold: state=%0d expected 0", state);
    end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL single_rearm: state=%0d expected 1", state);
    end
  endtask

  task automatic test_period();
    int gaps[$];
    int d;
    int e;
    trig_level = '0;
    trig_falling = 1'b1;
    gaps = '{100, 100};
    repeat (4) gaps.push_back(int'($urandom_range(150, 20)));
    gaps.push_back(PMAX - 1);
    gaps.push_back(PMAX + 900);
    gaps.push_back(37);
    drive_valid(-1000, 0);
    drive_valid(1000, 0);
    for (int g = 0; g < gaps.size(); g++) begin
      d = gaps[g];
      for (int j = 1; j < d; j++) drive_valid((j < d / 2) ? 800 : -800, g < 6 ? 1 : 0);
      drive_valid(1000, 0);
      e = (d > PMAX) ? PMAX : d;
      checks++;
      if (int'(period) !== e || period_valid !== 1'b1) begin
        failures++;
        $display("FAIL period_%0d: period=%0d valid=%0d expected %0d valid 1",
                 g, period, period_valid, e);
      end
    end
  endtask

  task automatic test_reset_mid_capture();
    trig_falling = 1'b0;
    decim = '0;
    drive_valid(-1000, 0);
    for (int i = 0; i < 50; i++) drive_valid(1000 + i, 0);
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL midrst_capture: state=%0d expected 2", state);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || wr_count !== '0 || period_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: state=%0d wr_count=%0d valid=%0d expected 0",
               state, wr_count, period_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal_square();
    test_decim_ramp();
    test_auto_timeout();
    test_falling_random();
    test_single();
    test_read_port();
    test_period();
    test_reset_mid_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
